mux_arb_n: RTL
==============

# mux_arb_n

Parametrised N-channel registered multiplexer with a valid/ready handshake on every input and on the output. It supersedes the fixed four-way combinational data mux wherever a datapath source crosses a pipeline boundary or several producers compete for one consumer. Channel choice is either an explicit selector or, when compiled in, round-robin arbitration. A single output register gives one-cycle latency at full throughput.

## Interface
Parameters:
- WIDTH, 32, data word width in bits (1..64).
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, derived as $clog2(CHANNELS), selector/channel-index width; never overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_i  input  WIDTH*CHANNELS  packed input words; channel k at [k*WIDTH +: WIDTH].
- valid_i  input  CHANNELS  per-channel valid.
- ready_o  output  CHANNELS  per-channel ready; at most one bit set in any cycle.
- selector  input  SEL_W  channel index used in select mode.
- mode_i  input  1  0 = select mode, 1 = round-robin mode; ignored when MUX_ARB_RR_EN is undefined.
- data_o  output  WIDTH  registered output word.
- valid_o  output  1  output register holds a word.
- ready_i  input  1  consumer ready.
- chan_o  output  SEL_W  source channel index of the word in data_o.

## Operation
- Input transfer on channel k: valid_i[k] && ready_o[k]. Output transfer: valid_o && ready_i.
- Load enable: load = !valid_o || ready_i, so the register accepts a new word when it is empty or is being drained in the same cycle.
- Grant, select mode: grant = selector when selector < CHANNELS and valid_i[selector] = 1. Otherwise there is no grant. An out-of-range selector never grants and never raises any ready_o bit.
- Grant, round-robin mode: the lowest-index valid channel, searching from ptr+1 and wrapping modulo CHANNELS. With no valid channel there is no grant.
- ready_o[k] = load && (grant exists) && (grant == k). Non-granted channels see ready_o = 0 whatever their valid_i.
- On an input transfer: data_o <= data_i[grant], chan_o <= grant, valid_o <= 1. In round-robin mode, ptr <= grant.
- On an output transfer with no input transfer: valid_o <= 0. data_o and chan_o hold their values.
- With no transfer, all state holds. A stalled output (valid_o=1, ready_i=0) keeps data_o and chan_o stable, and all ready_o bits are 0.
- ptr advances only on an accepted transfer in round-robin mode. Select-mode transfers leave it untouched.
- A change to mode_i or selector affects the grant in the same cycle. It never alters a word already held in the register.
- Inputs must hold data_i[k] stable while valid_i[k]=1 and ready_o[k]=0. Dropping valid_i before the transfer is legal; no word is taken.

## Timing
- Latency: 1 cycle from input transfer to valid_o/data_o. Throughput: 1 word per cycle when ready_i is held high.
- ready_o is combinational from valid_i, selector, mode_i, ready_i and state. There is no combinational path from any input to data_o, valid_o or chan_o.
- Reset values (asynchronous assert, released synchronously by the environment): data_o = 0, valid_o = 0, chan_o = 0, ptr = CHANNELS-1 (channel 0 wins the first round-robin grant).
- Reset mid-operation discards the held word immediately. ready_o drops to 0 while reset is high.
- Simultaneous drain and fill in one cycle: the new word replaces the old and valid_o stays 1.

## Configuration
- MUX_ARB_RR_EN defined: the round-robin grant logic and ptr register are built, and mode_i selects the mode.
- MUX_ARB_RR_EN undefined: only select mode exists. mode_i is unused, ptr is absent, and behaviour matches mode_i = 0 exactly.

## Test plan
- Reset check: assert reset with valid_i=4'b1111 and ready_i=1. Required: data_o=0, valid_o=0, chan_o=0, ready_o=0. After release, select mode with selector=2 and data_i[2]=32'hA5A5_0002 gives data_o=32'hA5A5_0002, chan_o=2, valid_o=1 one cycle later.
- Back-pressure: hold ready_i=0 after one transfer with selector=1. Required: valid_o=1, data_o stable, ready_o=0 every cycle. Raising ready_i for one cycle drains the word and refills from channel 1 in the same edge.
- Out-of-range: CHANNELS=3, selector=3, all valid. Required: ready_o=3'b000 and valid_o stays 0.
- Round-robin (macro on, mode_i=1): all four channels valid, ready_i=1. Required: chan_o sequence is 0,1,2,3,0. With only channels 1 and 3 valid, the sequence is 1,3,1,3.
- Round-robin pointer hold: after a grant to channel 2, stall ready_i=0 for 5 cycles. Required: the next grant is channel 3, not 0.
- Macro off: mode_i=1, selector=1, all valid. Required: every transfer comes from channel 1 (chan_o=1), identical to mode_i=0.

Source files
------------

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel registered multiplexer with a valid/ready handshake
// on every input and on the output. One output register gives one-cycle
// latency at full throughput.
// Channel choice is an explicit selector. When the MUX_ARB_RR_EN macro is
// defined, round-robin arbitration is also built and mode_i picks between
// the two. When the macro is undefined, mode_i is ignored.

// Per-channel handshake and data gating. The top level ORs the gated words
// together, so it needs no wide index mux.
module mux_arb_n_lane #(
    parameter int WIDTH = 32
) (
    input  logic             gnt,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic [WIDTH-1:0] data_gated
);
    // Only the granted channel sees ready, and only when the register can load.
    assign ready      = load & gnt;
    // A non-granted channel contributes zero to the OR tree.
    assign data_gated = gnt ? data : '0;
endmodule

module mux_arb_n #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH*CHANNELS-1:0] data_i,
    input  logic [CHANNELS-1:0]       valid_i,
    output logic [CHANNELS-1:0]       ready_o,
    input  logic [SEL_W-1:0]          selector,
    input  logic                      mode_i,
    output logic [WIDTH-1:0]          data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [SEL_W-1:0]          chan_o
);
    logic                           load;
    logic                           xfer_in;
    logic [CHANNELS-1:0]            sel_oh;
    logic [CHANNELS-1:0]            gnt_oh;
    logic                           gnt_vld;
    logic [SEL_W-1:0]               gnt_idx;
    logic [CHANNELS-1:0][WIDTH-1:0] data_gated;
    logic [WIDTH-1:0]               data_mux;

    // The register accepts a word when it is empty or is draining this cycle.
    // Reset forces every ready_o bit low while it is held.
    assign load = ~reset & (~valid_o | ready_i);

    // Select mode: decode the selector to one-hot. An out-of-range index
    // matches no channel, so it can never grant.
    always_comb begin
        sel_oh = '0;
        for (int k = 0; k < CHANNELS; k++)
            sel_oh[k] = valid_i[k] && (selector == SEL_W'(k));
    end

`ifdef MUX_ARB_RR_EN
    logic [SEL_W-1:0]    ptr;
    logic [CHANNELS-1:0] rr_oh;
    int                  rr_best;
    int                  rr_dist;

    // Round-robin: take the valid channel nearest after ptr, wrapping. The
    // distance of channel k is (k - ptr - 1) mod CHANNELS, so ptr+1 has
    // distance 0 and ptr itself has the largest distance.
    always_comb begin
        rr_oh   = '0;
        rr_best = CHANNELS;
        rr_dist = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            rr_dist = (k + 2*CHANNELS - 1 - int'(ptr)) % CHANNELS;
            if (valid_i[k] && rr_dist < rr_best) begin
                rr_best  = rr_dist;
                rr_oh    = '0;
                rr_oh[k] = 1'b1;
            end
        end
    end

    assign gnt_oh = mode_i ? rr_oh : sel_oh;

    // ptr follows the winner only on round-robin transfers. Reset sets it
    // to the last channel, so channel 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= SEL_W'(CHANNELS-1);
        else if (xfer_in && mode_i)
            ptr <= gnt_idx;
    end
`else
    logic unused_mode;

    assign unused_mode = mode_i;
    assign gnt_oh      = sel_oh;
`endif

    assign gnt_vld = |gnt_oh;
    assign xfer_in = load & gnt_vld;

    // Encode the one-hot grant into the channel index stored in chan_o.
    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < CHANNELS; k++)
            if (gnt_oh[k]) gnt_idx = SEL_W'(k);
    end

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_lane
            mux_arb_n_lane #(.WIDTH(WIDTH)) u_lane (
                .gnt        (gnt_oh[g]),
                .load       (load),
                .data       (data_i[g*WIDTH +: WIDTH]),
                .ready      (ready_o[g]),
                .data_gated (data_gated[g])
            );
        end
    endgenerate

    // OR the gated lane words together. At most one lane is non-zero.
    always_comb begin
        data_mux = '0;
        for (int k = 0; k < CHANNELS; k++)
            data_mux = data_mux | data_gated[k];
    end

    // Output register. A fill wins over a drain, and a drain alone only
    // clears valid_o, so data_o and chan_o keep the last word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            chan_o  <= '0;
        end else if (xfer_in) begin
            data_o  <= data_mux;
            valid_o <= 1'b1;
            chan_o  <= gnt_idx;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end
endmodule
